// File: rtl/bit_sync_recovery.sv
// Symbol-timing recovery: tracks symbol phase from data transitions of an
// oversampled bit stream and emits one mid-symbol decision per symbol.
module bit_sync_recovery #(
   parameter int OVERSAMPLE    = 16,
   parameter int TOL           = 2,
   parameter int LOCK_EDGES    = 4,
   parameter int UNLOCK_MISSES = 3,
   parameter int MAX_RUN       = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_in,
   output logic bit_out,
   output logic bit_valid,
   output logic locked
);

   localparam int CW = $clog2(OVERSAMPLE) + 1;
   localparam int GW = $clog2(LOCK_EDGES) + 1;
   localparam int MW = $clog2(UNLOCK_MISSES) + 1;
   localparam int RW = $clog2(MAX_RUN) + 1;

   localparam logic [CW-1:0] CNT_MAX_C  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_C     = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] TOL_C      = CW'(TOL);
   localparam logic [CW-1:0] HI_TOL_C   = CW'(OVERSAMPLE - TOL);
   localparam logic [CW-1:0] WRAP2_C    = CW'(OVERSAMPLE - 2);
   localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_EDGES);
   localparam logic [MW-1:0] UNLOCK_C   = MW'(UNLOCK_MISSES);
   localparam logic [RW-1:0] RUN_MAX_C  = RW'(MAX_RUN);
   localparam logic [RW-1:0] RUN_LAST_C = RW'(MAX_RUN - 1);

   localparam logic [0:0] ST_ACQUIRE = 1'b0;
   localparam logic [0:0] ST_TRACK   = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] good_q, good_d;
   logic [MW-1:0] miss_q, miss_d;
   logic [RW-1:0] run_q, run_d;
   logic          bit_q;
   logic          out_q, out_d;
   logic          valid_q, valid_d;

   logic          edge_det;
   logic          sample;
   logic          in_tol;
   logic          good_edge;
   logic          timeout;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] cnt_early;
   logic [GW-1:0] good_inc;
   logic [MW-1:0] miss_inc;

   always_comb begin
      edge_det  = bit_in ^ bit_q;
      sample    = (cnt_q == HALF_C);
      in_tol    = (cnt_q <= TOL_C) || (cnt_q >= HI_TOL_C);
      good_edge = edge_det && in_tol;
      cnt_inc   = (cnt_q == CNT_MAX_C) ? '0 : cnt_q + 1'b1;
      cnt_early = (cnt_q >= WRAP2_C) ? cnt_q - WRAP2_C : cnt_q + CW'(2);
      good_inc  = good_q + 1'b1;
      miss_inc  = miss_q + 1'b1;
      // An edge clears the run counter, so it pre-empts a same-cycle timeout.
      timeout   = !edge_det && sample && (run_q == RUN_LAST_C);

      out_d   = sample ? bit_in : out_q;
      valid_d = sample;

      if (edge_det) begin
         run_d = '0;
      end else if (sample && (run_q != RUN_MAX_C)) begin
         run_d = run_q + 1'b1;
      end else begin
         run_d = run_q;
      end

      state_d = state_q;
      cnt_d   = cnt_inc;
      good_d  = good_q;
      miss_d  = miss_q;

      if (state_q == ST_ACQUIRE) begin
         if (edge_det) begin
            cnt_d = CW'(1);
            if (good_edge) begin
               good_d = good_inc;
               if (good_inc >= LOCK_C) begin
                  state_d = ST_TRACK;
                  miss_d  = '0;
               end
            end else begin
               good_d = '0;
            end
         end else if (timeout) begin
            good_d = '0;
         end
      end else begin
         if (edge_det) begin
            // One-clock phase nudge: late edges stretch, early edges shorten.
            if (cnt_q == '0) begin
               cnt_d = CW'(1);
            end else if (cnt_q < HALF_C) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_early;
            end
            if (good_edge) begin
               miss_d = '0;
            end else begin
               miss_d = miss_inc;
               if (miss_inc >= UNLOCK_C) begin
                  state_d = ST_ACQUIRE;
                  good_d  = '0;
               end
            end
         end else if (timeout) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACQUIRE;
         cnt_q   <= '0;
         good_q  <= '0;
         miss_q  <= '0;
         run_q   <= '0;
         bit_q   <= 1'b0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         good_q  <= good_d;
         miss_q  <= miss_d;
         run_q   <= run_d;
         bit_q   <= bit_in;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign bit_out   = out_q;
   assign bit_valid = valid_q;
   assign locked    = (state_q == ST_TRACK);

endmodule

// File: tb/tb_bit_sync_recovery.sv
// Directed bench for bit_sync_recovery: segment table of symbol streams plus
// hand-timed sequences for unlock, mid-symbol reset and run-length timeout.
module tb_bit_sync_recovery;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_in = 1'b0;
   logic bit_out, bit_valid, locked;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          period;
      int          nbits;
      logic [31:0] pat;
      int          skip;
      logic        exp_lock;
      int          seq;
   } seg_t;

   seg_t segs[9];

   bit_sync_recovery #(
      .OVERSAMPLE(16),
      .TOL(2),
      .LOCK_EDGES(4),
      .UNLOCK_MISSES(3),
      .MAX_RUN(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bit_in(bit_in),
      .bit_out(bit_out),
      .bit_valid(bit_valid),
      .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic run_seg(input seg_t sg);
      int last = -1;
      int ns;
      logic b;
      logic [31:0] p;
      p = sg.pat;
      for (int i = 0; i < sg.nbits; i++) begin
         b  = p[i % 32];
         ns = 0;
         for (int c = 0; c < sg.period; c++) begin
            tick();
            if (bit_valid) begin
               ns++;
               if (i >= sg.skip) begin
                  check("seg_bit", bit_out, b);
                  check("seg_locked", locked, sg.exp_lock);
                  if (sg.period == 16 && i > sg.skip && last >= 0)
                     check("seg_gap", cyc - last, 16);
               end
               last = cyc;
            end
            if (c == 0) bit_in = b;
         end
         if (i >= sg.skip) check("seg_strobes", ns, 1);
      end
   endtask

   task automatic run_seq(input int id);
      logic hv = 1'b0;
      int   n = 0;
      bit   done = 1'b0;
      case (id)
         1: begin
            // Bad, good, bad, bad: misses never reach three in a row.
            for (int k = 0; k < 45; k++) begin
               tick();
               if (k == 9) begin
                  check("half_edge_valid", bit_valid, 1);
                  check("half_edge_sample", bit_out, hv);
               end
               if (k == 39 || k == 44) check("lock_hold", locked, 1);
               if (k == 8 || k == 15 || k == 23 || k == 38) bit_in = ~bit_in;
               if (k == 8) hv = bit_in;
            end
         end
         2: begin
            for (int k = 0; k < 45; k++) begin
               tick();
               if (k == 38) check("unlock_pre", locked, 1);
               if (k == 39) check("unlock", locked, 0);
               if (k == 8 || k == 23 || k == 38) bit_in = ~bit_in;
            end
         end
         3: begin
            for (int k = 0; k < 86; k++) begin
               tick();
               if (k == 9) begin
                  check("pre_rst_valid", bit_valid, 1);
                  check("pre_rst_bit", bit_out, 1);
               end
               if (k == 21) begin
                  check("pre_rst_lock", locked, 1);
                  rst = 1'b1;
               end
               if (k == 22) begin
                  check("rst_bit_out", bit_out, 0);
                  check("rst_bit_valid", bit_valid, 0);
                  check("rst_locked", locked, 0);
                  rst = 1'b0;
               end
               if (k == 70) check("relock_pre", locked, 0);
               if (k == 71) check("relock", locked, 1);
               if (k == 0) bit_in = 1'b1;
               if (k == 16) bit_in = 1'b0;
               if (k == 22 || k == 38 || k == 54 || k == 70) bit_in = ~bit_in;
            end
         end
         4: begin
            for (int k = 0; k < 16 + 40 * 16 && !done; k++) begin
               tick();
               if (k > 16 && bit_valid) begin
                  n++;
                  check("run_bit", bit_out, 1);
                  if (n == 31) check("run_lock31", locked, 1);
                  if (n == 32) done = 1'b1;
               end
               if (k == 0) bit_in = 1'b0;
               if (k == 16) bit_in = 1'b1;
            end
            check("run_strobes", n, 32);
            tick();
            check("run_unlock", locked, 0);
         end
         default: ;
      endcase
   endtask

   initial begin
      segs[0] = '{period:16, nbits:12,  pat:32'hAAAA_AAAA, skip:6, exp_lock:1'b1, seq:0};
      segs[1] = '{period:17, nbits:200, pat:32'hAAAA_AAAA, skip:0, exp_lock:1'b1, seq:0};
      segs[2] = '{period:16, nbits:16,  pat:32'hAAAA_AAAA, skip:0, exp_lock:1'b1, seq:0};
      segs[3] = '{period:15, nbits:200, pat:32'hAAAA_AAAA, skip:0, exp_lock:1'b1, seq:0};
      segs[4] = '{period:16, nbits:40,  pat:32'hC6A5_3B94, skip:0, exp_lock:1'b1, seq:1};
      segs[5] = '{period:16, nbits:8,   pat:32'hAAAA_AAAA, skip:0, exp_lock:1'b1, seq:2};
      segs[6] = '{period:16, nbits:12,  pat:32'hAAAA_AAAA, skip:6, exp_lock:1'b1, seq:3};
      segs[7] = '{period:16, nbits:4,   pat:32'hAAAA_AAAA, skip:0, exp_lock:1'b1, seq:4};
      segs[8] = '{period:16, nbits:16,  pat:32'hC6A5_3B94, skip:6, exp_lock:1'b1, seq:0};

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_out", bit_out, 0);
         check("rst_valid", bit_valid, 0);
         check("rst_lock", locked, 0);
         bit_in = ~bit_in;
      end
      rst    = 1'b0;
      bit_in = 1'b0;
      tick();
      check("post_rst_out", bit_out, 0);
      check("post_rst_valid", bit_valid, 0);
      check("post_rst_lock", locked, 0);

      for (int s = 0; s < 9; s++) begin
         run_seg(segs[s]);
         run_seq(segs[s].seq);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_sync_recovery.md
# bit_sync_recovery

Symbol-timing recovery stage directly downstream of the median filter. Takes the filtered, oversampled bit stream (one sample per clock), tracks the symbol phase from data transitions, and emits one decided bit per symbol at mid-symbol with a valid strobe. Also reports a lock indicator so the consumers downstream can ignore bits during acquisition.

## Interface
- OVERSAMPLE, 16: clocks per symbol; even, ≥ 4.
- TOL, 2: edge phase tolerance in clocks; must be < OVERSAMPLE/4.
- LOCK_EDGES, 4: consecutive in-tolerance edges required to lock.
- UNLOCK_MISSES, 3: consecutive out-of-tolerance edges that drop lock.
- MAX_RUN, 32: symbols without any edge before lock is dropped.
- clk  in  1  system clock; one clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- bit_in  in  1  filtered bit stream (median filter output), one sample per clk.
- bit_out  out  1  recovered symbol value.
- bit_valid  out  1  one-cycle pulse when bit_out is updated.
- locked  out  1  high while in TRACK state.

## Operation
- Reset values: bit_out=0, bit_valid=0, locked=0, state=ACQUIRE, phase counter cnt=0, bit_q=0, good/miss/run counters=0.
- bit_q <= bit_in every cycle; edge = (bit_in != bit_q), combinational in the current cycle. First 1 after reset therefore counts as an edge.
- cnt runs 0..OVERSAMPLE-1, increments and wraps when no edge adjustment applies. HALF = OVERSAMPLE/2.
- Sample: in any cycle with cnt==HALF, bit_out <= bit_in, bit_valid <= 1 (else bit_valid <= 0). Sampling runs in both states; consumers qualify with locked.
- Edge classification uses cnt value in the edge cycle: good if cnt ≤ TOL or cnt ≥ OVERSAMPLE-TOL; otherwise bad.
- ACQUIRE: on edge, cnt <= 1 (hard resync; edge cycle = phase 0). Good edge: good_cnt+1; bad edge: good_cnt <= 0. When good_cnt reaches LOCK_EDGES (including the current edge) → TRACK, miss_cnt <= 0.
- TRACK: on edge, nudge by one clock only: cnt==0 → cnt <= 1; cnt in 1..HALF-1 (late edge) → cnt <= cnt (hold); cnt in HALF..OVERSAMPLE-1 (early edge) → cnt <= (cnt+2) mod OVERSAMPLE. Good edge: miss_cnt <= 0; bad edge: miss_cnt+1; reaching UNLOCK_MISSES → ACQUIRE, good_cnt <= 0.
- Run counter: cleared on edge, +1 per sample event, saturates at MAX_RUN. Reaching MAX_RUN: in TRACK → ACQUIRE, good_cnt <= 0; in ACQUIRE → good_cnt <= 0.
- Counter widths: $clog2 of respective limit + 1; no counter wraps.

## Timing
- bit_out/bit_valid registered: the value of bit_in in the cnt==HALF cycle appears on bit_out, with bit_valid=1, in the following cycle.
- locked changes the cycle after the qualifying edge/timeout event.
- Edge coinciding with cnt==HALF: sample takes the new bit_in value in that cycle; edge is classified bad and cnt adjusted per state rules.
- Edge and run-counter saturation in the same cycle: edge wins (run cleared, no timeout).
- Bad edge reaching UNLOCK_MISSES and timeout in the same cycle: single transition to ACQUIRE.
- rst mid-operation: all state returns to reset values on the next clock, regardless of state; bit_valid low that cycle.
- Steady-state throughput: exactly one bit_valid per OVERSAMPLE clocks absent edge nudges; a nudge shifts the next strobe by ±1 clock.

## Test plan
- Reset: hold rst 3 cycles with bit_in toggling -> bit_out=0, bit_valid=0, locked=0 throughout and one cycle after release.
- Alternating 1010… at exactly 16 clk/bit -> locked=1 by the 6th edge; afterwards each bit_valid carries the transmitted bit, strobes exactly 16 clk apart.
- Locked, then period changes to 17 clk/bit for 200 bits (and 15 clk/bit for 200 bits) -> locked stays 1, no missing or duplicated bits.
- Locked, then three consecutive edges at cnt=8 -> locked falls the cycle after the third; one good edge in between instead -> locked stays 1.
- Locked, then bit_in held at 1 -> locked falls after the 32nd bit_valid since the last edge; bit_out=1 on all those strobes.
- Locked, assert rst for 1 cycle mid-symbol -> all outputs 0 next cycle, re-lock after LOCK_EDGES good edges.
